mem_rd_arbiter: RTL and testbench
=================================

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, SHALL select the arbitration policy: 0 = round-robin, 1 = D-cache always wins ties.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 ic_rd_req_valid / ic_rd_req_addr / ic_rd_req_ready: input 1 / input 32 / output 1; SHALL carry the I-cache 32-byte line read request.
REQ-005 ic_rd_rsp_valid / ic_rd_rsp_data / ic_rd_rsp_last / ic_rd_rsp_ready: output 1 / output 32 / output 1 / input 1; SHALL carry the I-cache burst return.
REQ-006 dc_rd_req_valid / dc_rd_req_addr / dc_rd_req_ready and dc_rd_rsp_valid / dc_rd_rsp_data / dc_rd_rsp_last / dc_rd_rsp_ready SHALL carry the same widths and directions for the D-cache.
REQ-007 mem_rd_req_valid  output 1; mem_rd_req_addr  output 32; mem_rd_req_ready  input 1 SHALL form the shared memory read request channel.
REQ-008 mem_rd_rsp_valid  input 1; mem_rd_rsp_data  input 32; mem_rd_rsp_last  input 1; mem_rd_rsp_ready  output 1 SHALL form the shared memory response channel.

Function
REQ-009 SHALL implement an FSM with states IDLE, REQ and RSP; only one burst SHALL be outstanding at a time.
REQ-010 IDLE: if any request valid is high, SHALL register grant (IC or DC) and the granted address with bits [4:0] forced to 0, then move to REQ next cycle.
REQ-011 Tie in IDLE with FIXED_PRIO=0: SHALL grant the requester not granted last; last-grant pointer SHALL reset to IC, so the first tie goes to DC.
REQ-012 Tie in IDLE with FIXED_PRIO=1: SHALL grant DC.
REQ-013 REQ: mem_rd_req_valid SHALL be 1 and mem_rd_req_addr SHALL be the latched address; both SHALL be held stable until mem_rd_req_ready.
REQ-014 REQ: the granted requester's req_ready SHALL equal mem_rd_req_ready (combinational); the other's req_ready SHALL be 0.
REQ-015 In IDLE and RSP, both req_ready outputs SHALL be 0.
REQ-016 REQ and mem_rd_req_ready=1: SHALL move to RSP next cycle and update the last-grant pointer.
REQ-017 RSP: the granted side's rsp_valid/rsp_data/rsp_last SHALL equal the mem_rd_rsp_* inputs combinationally, and mem_rd_rsp_ready SHALL equal the granted side's rsp_ready.
REQ-018 RSP: the non-granted side's rsp_valid and rsp_last SHALL be 0 and its rsp_data SHALL be 0.
REQ-019 Beat handshake with mem_rd_rsp_last=1 in RSP SHALL return the FSM to IDLE next cycle; non-last beats SHALL stay in RSP.
REQ-020 Minimum latency from request valid (IDLE) to mem_rd_req_valid SHALL be 1 cycle; there SHALL be 1 idle cycle between the last beat and the next grant.
REQ-021 Request valid deasserted by a requester after grant SHALL NOT cancel the transaction (caches hold valid until ready by protocol).
REQ-022 mem_rd_rsp_valid arriving in IDLE or REQ SHALL be ignored with mem_rd_rsp_ready=0.

Reset
REQ-023 When rst=1 at a clock edge, the FSM SHALL enter IDLE, the last-grant pointer SHALL be set to IC, and the latched address SHALL be cleared to 0.
REQ-024 During reset, all valid/ready/last outputs SHALL be 0 and mem_rd_req_addr SHALL be 0.
REQ-025 Reset mid-burst SHALL abandon the burst with no beat forwarded afterwards; the memory side SHALL share the same reset.

Verification
REQ-026 Only IC valid, addr 0x0000_1234, mem ready=1 -> the next cycle gives mem_rd_req_valid=1 with addr 0x0000_1220; 8 beats 0xA0..0xA7 with last on beat 8 -> ic_rd_rsp sees all 8 in order, dc_rd_rsp_valid stays 0.
REQ-027 IC and DC valid together after reset, FIXED_PRIO=0 -> DC is granted first; IC is granted after DC's last beat plus one IDLE cycle.
REQ-028 Both valid continuously for 4 bursts, FIXED_PRIO=0 -> grant order DC, IC, DC, IC; with FIXED_PRIO=1 -> grant order DC, DC, DC, DC.
REQ-029 mem_rd_req_ready held 0 for 5 cycles in REQ -> valid and addr remain stable, granted req_ready=0, and the FSM stays in REQ.
REQ-030 Granted rsp_ready=0 for 3 cycles mid-burst -> mem_rd_rsp_ready=0 for those cycles, no beat is lost or duplicated, and exactly 8 beats are delivered.
REQ-031 rst asserted after beat 3 of 8 -> the FSM is in IDLE next cycle, all outputs are 0, and a new IC request is served normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Two-client (I-cache / D-cache) burst read arbiter onto a single memory
// read port. One burst outstanding at a time; IDLE -> REQ -> RSP -> IDLE.
module mem_rd_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ic_rd_req_valid,
  input  logic [31:0] ic_rd_req_addr,
  output logic        ic_rd_req_ready,
  output logic        ic_rd_rsp_valid,
  output logic [31:0] ic_rd_rsp_data,
  output logic        ic_rd_rsp_last,
  input  logic        ic_rd_rsp_ready,

  input  logic        dc_rd_req_valid,
  input  logic [31:0] dc_rd_req_addr,
  output logic        dc_rd_req_ready,
  output logic        dc_rd_rsp_valid,
  output logic [31:0] dc_rd_rsp_data,
  output logic        dc_rd_rsp_last,
  input  logic        dc_rd_rsp_ready,

  output logic        mem_rd_req_valid,
  output logic [31:0] mem_rd_req_addr,
  input  logic        mem_rd_req_ready,

  input  logic        mem_rd_rsp_valid,
  input  logic [31:0] mem_rd_rsp_data,
  input  logic        mem_rd_rsp_last,
  output logic        mem_rd_rsp_ready
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t      state;
  logic        grant_dc;   // 1: current burst belongs to the D-cache
  logic        last_dc;    // 1: most recent accepted request was the D-cache
  logic [31:0] addr_q;
  logic        pick_dc;
  logic        in_req;
  logic        in_rsp;
  logic        rsp_ic;
  logic        rsp_dc;

  // Arbitration decision for the IDLE state
  always_comb begin
    pick_dc = 1'b0;
    if (dc_rd_req_valid && !ic_rd_req_valid) begin
      pick_dc = 1'b1;
    end else if (dc_rd_req_valid && ic_rd_req_valid) begin
      pick_dc = (FIXED_PRIO != 0) ? 1'b1 : !last_dc;
    end
  end

  // Control FSM: grant/address latch, request handshake, burst tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_dc <= 1'b0;
      last_dc  <= 1'b0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_rd_req_valid || dc_rd_req_valid) begin
            grant_dc <= pick_dc;
            addr_q   <= pick_dc ? {dc_rd_req_addr[31:5], 5'b0}
                                : {ic_rd_req_addr[31:5], 5'b0};
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_req_ready) begin
            last_dc <= grant_dc;
            state   <= RSP;
          end
        end
        RSP: begin
          if (mem_rd_rsp_valid && mem_rd_rsp_ready && mem_rd_rsp_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering; rst forces every output low even before the first edge
  always_comb begin
    in_req = (state == REQ) && !rst;
    in_rsp = (state == RSP) && !rst;
    rsp_ic = in_rsp && !grant_dc;
    rsp_dc = in_rsp && grant_dc;

    mem_rd_req_valid = in_req;
    mem_rd_req_addr  = in_req ? addr_q : '0;
    ic_rd_req_ready  = in_req && !grant_dc && mem_rd_req_ready;
    dc_rd_req_ready  = in_req && grant_dc && mem_rd_req_ready;

    ic_rd_rsp_valid  = rsp_ic && mem_rd_rsp_valid;
    ic_rd_rsp_data   = rsp_ic ? mem_rd_rsp_data : '0;
    ic_rd_rsp_last   = rsp_ic && mem_rd_rsp_last;
    dc_rd_rsp_valid  = rsp_dc && mem_rd_rsp_valid;
    dc_rd_rsp_data   = rsp_dc ? mem_rd_rsp_data : '0;
    dc_rd_rsp_last   = rsp_dc && mem_rd_rsp_last;

    mem_rd_rsp_ready = (rsp_ic && ic_rd_rsp_ready) || (rsp_dc && dc_rd_rsp_ready);
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd_req_valid, dc_rd_req_valid;
  logic [31:0] ic_rd_req_addr, dc_rd_req_addr;
  logic        ic_rd_rsp_ready, dc_rd_rsp_ready;
  logic        mem_rd_req_ready;
  logic        mem_rd_rsp_valid, mem_rd_rsp_last;
  logic [31:0] mem_rd_rsp_data;

  logic        ic_rd_req_ready, dc_rd_req_ready;
  logic        ic_rd_rsp_valid, dc_rd_rsp_valid, ic_rd_rsp_last, dc_rd_rsp_last;
  logic [31:0] ic_rd_rsp_data, dc_rd_rsp_data;
  logic        mem_rd_req_valid, mem_rd_rsp_ready;
  logic [31:0] mem_rd_req_addr;

  logic        fp_ic_req_ready, fp_dc_req_ready;
  logic        fp_ic_rsp_valid, fp_dc_rsp_valid, fp_ic_rsp_last, fp_dc_rsp_last;
  logic [31:0] fp_ic_rsp_data, fp_dc_rsp_data;
  logic        fp_mem_req_valid, fp_mem_rsp_ready;
  logic [31:0] fp_mem_req_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
    .ic_rd_req_ready(ic_rd_req_ready),
    .ic_rd_rsp_valid(ic_rd_rsp_valid), .ic_rd_rsp_data(ic_rd_rsp_data),
    .ic_rd_rsp_last(ic_rd_rsp_last), .ic_rd_rsp_ready(ic_rd_rsp_ready),
    .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
    .dc_rd_req_ready(dc_rd_req_ready),
    .dc_rd_rsp_valid(dc_rd_rsp_valid), .dc_rd_rsp_data(dc_rd_rsp_data),
    .dc_rd_rsp_last(dc_rd_rsp_last), .dc_rd_rsp_ready(dc_rd_rsp_ready),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
    .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_data(mem_rd_rsp_data),
    .mem_rd_rsp_last(mem_rd_rsp_last), .mem_rd_rsp_ready(mem_rd_rsp_ready)
  );

  mem_rd_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
    .ic_rd_req_ready(fp_ic_req_ready),
    .ic_rd_rsp_valid(fp_ic_rsp_valid), .ic_rd_rsp_data(fp_ic_rsp_data),
    .ic_rd_rsp_last(fp_ic_rsp_last), .ic_rd_rsp_ready(ic_rd_rsp_ready),
    .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
    .dc_rd_req_ready(fp_dc_req_ready),
    .dc_rd_rsp_valid(fp_dc_rsp_valid), .dc_rd_rsp_data(fp_dc_rsp_data),
    .dc_rd_rsp_last(fp_dc_rsp_last), .dc_rd_rsp_ready(dc_rd_rsp_ready),
    .mem_rd_req_valid(fp_mem_req_valid), .mem_rd_req_addr(fp_mem_req_addr),
    .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_data(mem_rd_rsp_data),
    .mem_rd_rsp_last(mem_rd_rsp_last), .mem_rd_rsp_ready(fp_mem_rsp_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after entering REQ; completes the request handshake.
  task automatic req_phase(input logic exp_dc, input logic [31:0] exp_addr, input logic fp_exp_dc);
    mem_rd_req_ready = 1'b1;
    #1;
    chk("req_valid", mem_rd_req_valid, 1'b1);
    chk("req_addr", mem_rd_req_addr, exp_addr);
    chk("ic_req_ready", ic_rd_req_ready, !exp_dc);
    chk("dc_req_ready", dc_rd_req_ready, exp_dc);
    chk("fp_dc_req_ready", fp_dc_req_ready, fp_exp_dc);
    chk("fp_ic_req_ready", fp_ic_req_ready, !fp_exp_dc);
    tick();
  endtask

  // Drives 8 beats base..base+7; granted side withholds ready 3 cycles at beat stall_at.
  task automatic burst(input logic to_dc, input logic [31:0] base, input int stall_at);
    int sent = 0;
    int got = 0;
    int stall = 0;
    logic rdy;
    while (sent < 8) begin
      rdy = !(sent == stall_at && stall < 3);
      mem_rd_rsp_valid = 1'b1;
      mem_rd_rsp_data  = base + 32'(sent);
      mem_rd_rsp_last  = (sent == 7);
      ic_rd_rsp_ready  = to_dc ? 1'b1 : rdy;
      dc_rd_rsp_ready  = to_dc ? rdy : 1'b1;
      #1;
      chk("rsp_req_valid_low", mem_rd_req_valid, 1'b0);
      chk("rsp_valid", to_dc ? dc_rd_rsp_valid : ic_rd_rsp_valid, 1'b1);
      chk("rsp_data", to_dc ? dc_rd_rsp_data : ic_rd_rsp_data, base + 32'(sent));
      chk("rsp_last", to_dc ? dc_rd_rsp_last : ic_rd_rsp_last, (sent == 7));
      chk("other_rsp", to_dc ? {ic_rd_rsp_valid, ic_rd_rsp_last, ic_rd_rsp_data}
                             : {dc_rd_rsp_valid, dc_rd_rsp_last, dc_rd_rsp_data}, '0);
      chk("mem_rsp_ready", mem_rd_rsp_ready, rdy);
      if (to_dc ? (dc_rd_rsp_valid && dc_rd_rsp_ready) : (ic_rd_rsp_valid && ic_rd_rsp_ready))
        got++;
      if (rdy) sent++;
      else stall++;
      tick();
    end
    chk("beat_count", got, 8);
    mem_rd_rsp_valid = 1'b0;
    mem_rd_rsp_last  = 1'b0;
    ic_rd_rsp_ready  = 1'b1;
    dc_rd_rsp_ready  = 1'b1;
    #1;
    chk("post_burst_idle", mem_rd_rsp_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ic_rd_req_valid = 1'b0; dc_rd_req_valid = 1'b0;
    ic_rd_req_addr = '0; dc_rd_req_addr = '0;
    ic_rd_rsp_ready = 1'b1; dc_rd_rsp_ready = 1'b1;
    mem_rd_req_ready = 1'b1;
    mem_rd_rsp_valid = 1'b1; mem_rd_rsp_last = 1'b1; mem_rd_rsp_data = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    // Reset state with live-looking inputs on every channel
    chk("rst_outs", {mem_rd_req_valid, mem_rd_req_addr, ic_rd_req_ready, dc_rd_req_ready,
                     ic_rd_rsp_valid, ic_rd_rsp_last, dc_rd_rsp_valid, dc_rd_rsp_last,
                     mem_rd_rsp_ready}, '0);
    chk("rst_fp_outs", {fp_mem_req_valid, fp_mem_req_addr, fp_ic_req_ready, fp_dc_req_ready,
                        fp_ic_rsp_valid, fp_ic_rsp_last, fp_ic_rsp_data, fp_dc_rsp_valid,
                        fp_dc_rsp_last, fp_dc_rsp_data, fp_mem_rsp_ready}, '0);
    mem_rd_rsp_valid = 1'b0; mem_rd_rsp_last = 1'b0;
    rst = 1'b0;
    tick();

    // Single IC request, address aligned down, 8-beat return
    ic_rd_req_valid = 1'b1; ic_rd_req_addr = 32'h0000_1234;
    #1;
    chk("idle_req_valid", mem_rd_req_valid, 1'b0);
    chk("idle_ic_req_ready", ic_rd_req_ready, 1'b0);
    tick();
    req_phase(1'b0, 32'h0000_1220, 1'b0);
    ic_rd_req_valid = 1'b0;
    burst(1'b0, 32'h0000_00A0, 99);

    // Memory request stall for 5 cycles, then response stall mid-burst
    tick();
    ic_rd_req_valid = 1'b1; ic_rd_req_addr = 32'h0000_2010;
    mem_rd_req_ready = 1'b0;
    tick();
    ic_rd_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_valid", mem_rd_req_valid, 1'b1);
      chk("stall_req_addr", mem_rd_req_addr, 32'h0000_2000);
      chk("stall_ic_req_ready", ic_rd_req_ready, 1'b0);
      tick();
    end
    req_phase(1'b0, 32'h0000_2000, 1'b0);
    burst(1'b0, 32'h0000_00B0, 3);

    // Reset after beat 3 of 8 abandons the burst
    tick();
    ic_rd_req_valid = 1'b1; ic_rd_req_addr = 32'h0000_3000;
    tick();
    ic_rd_req_valid = 1'b0;
    req_phase(1'b0, 32'h0000_3000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_rd_rsp_valid = 1'b1; mem_rd_rsp_data = 32'hC0 + 32'(i); mem_rd_rsp_last = 1'b0;
      #1;
      chk("pre_rst_beat", ic_rd_rsp_data, 32'hC0 + 32'(i));
      tick();
    end
    rst = 1'b1;
    mem_rd_rsp_data = 32'hC3;
    #1;
    chk("rst_mid_rsp", {ic_rd_rsp_valid, ic_rd_rsp_data, mem_rd_rsp_ready}, '0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_outs", {ic_rd_rsp_valid, ic_rd_rsp_data, mem_rd_rsp_ready,
                           mem_rd_req_valid, mem_rd_req_addr}, '0);
    mem_rd_rsp_valid = 1'b0;
    ic_rd_req_valid = 1'b1; ic_rd_req_addr = 32'h0000_4004;
    tick();
    ic_rd_req_valid = 1'b0;
    req_phase(1'b0, 32'h0000_4000, 1'b0);
    burst(1'b0, 32'h0000_00D0, 99);

    // Fresh reset, then both caches request continuously for 4 bursts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ic_rd_req_valid = 1'b1; ic_rd_req_addr = 32'h0000_011F;
    dc_rd_req_valid = 1'b1; dc_rd_req_addr = 32'h0000_023F;
    tick();
    for (int k = 0; k < 4; k++) begin
      req_phase(k % 2 == 0, (k % 2 == 0) ? 32'h0000_0220 : 32'h0000_0100, 1'b1);
      burst(k % 2 == 0, 32'h100 * (k + 1), 99);
      chk("idle_gap", mem_rd_req_valid, 1'b0);
      if (k == 3) begin
        ic_rd_req_valid = 1'b0;
        dc_rd_req_valid = 1'b0;
      end
      tick();
    end
    #1;
    chk("final_idle", {mem_rd_req_valid, fp_mem_req_valid}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
